// File: rtl/buffer_ram_slot_if.sv
// Buffer-interconnect RAM slot bundle: the routed request, read data, clear engine and error flag.
// The master is the interconnect side and the slave is the RAM bank.
interface buffer_ram_slot_if #(
  parameter int DATA_SIZE = 512
);
  typedef struct packed {
    logic [31:0]          raddr;
    logic [31:0]          waddr;
    logic [DATA_SIZE-1:0] wdata;
    logic                 wren;
  } ram_in_t;

  // There is no valid and no ready. One request is presented and consumed on every clock.
  // Unused slots present an all-zero request, which reads index 0 and writes nothing.
  ram_in_t              ram_in;
  logic [DATA_SIZE-1:0] ram_out;
  logic                 clear_req;
  logic                 clear_busy;
  logic                 err_oor;
  logic                 err_clr;
  logic                 dbg_state;

  modport master (
    output ram_in, clear_req, err_clr,
    input  ram_out, clear_busy, err_oor, dbg_state
  );

  modport slave (
    input  ram_in, clear_req, err_clr,
    output ram_out, clear_busy, err_oor, dbg_state
  );
endinterface

// File: rtl/buffer_ram_slot.sv
// One buffer RAM bank per interconnect slot. Reads are write-first, and the read latency is fixed.
// The bank adds a whole-bank clear engine and a sticky out-of-range error flag.
module buffer_ram_slot #(
  parameter int DATA_SIZE = 512,
  parameter int DEPTH     = 1024,
  parameter int CYCLES    = 2
) (
  input  logic              clk,
  input  logic              rst,
  buffer_ram_slot_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic                 err_q, err_d;
  logic [DATA_SIZE-1:0] pipe_q [CYCLES];
  logic [DATA_SIZE-1:0] pipe_d [CYCLES];

  logic [AW-1:0]        ridx, widx;
  logic                 r_in, w_in, wr_ok;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] rd_data;

  assign ridx  = bus.ram_in.raddr[AW-1:0];
  assign widx  = bus.ram_in.waddr[AW-1:0];
  assign r_in  = (bus.ram_in.raddr[31:AW] == '0);
  assign w_in  = (bus.ram_in.waddr[31:AW] == '0);
  assign wr_ok = bus.ram_in.wren && w_in && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While clearing, the clear engine owns the write port and external writes are dropped.
  always_comb begin
    mem_we    = wr_ok;
    mem_addr  = widx;
    mem_wdata = bus.ram_in.wdata;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = ptr_q;
      mem_wdata = '0;
    end
  end

  always_comb begin
    rd_data = mem[ridx];
    if (state_q == CLEAR || !r_in) rd_data = '0;
    else if (wr_ok && widx == ridx) rd_data = bus.ram_in.wdata;
  end

  always_comb begin
    pipe_d[0] = rd_data;
    for (int i = 1; i < CYCLES; i++) pipe_d[i] = pipe_q[i-1];
  end

  // A new event in the same cycle overrides err_clr, so the set wins.
  always_comb begin
    err_d = err_q;
    if (bus.err_clr) err_d = 1'b0;
    if (!r_in || (bus.ram_in.wren && !w_in && state_q == IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < CYCLES; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int i = 0; i < CYCLES; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign bus.ram_out    = pipe_q[CYCLES-1];
  assign bus.clear_busy = (state_q == CLEAR);
  assign bus.err_oor    = err_q;
  assign bus.dbg_state  = state_q;
endmodule
